if_fetch: RTL
=============

# if_fetch

Instruction-fetch stage directly downstream of the PC register. It takes the current `pc` and looks it up in a direct-mapped instruction cache. On a miss it fetches the 32-bit word byte-serially through the memory controller and requests a front-end stall. It presents `inst`/`inst_pc`/`inst_valid` to the IF/ID register and squashes all in-flight work on `jump_flag`.

## Interface
Parameters:
- `ICACHE_IDX_W`, default 7: index width. The index is `pc[ICACHE_IDX_W+1:2]`, giving 128 entries.
- `ICACHE_TAG_W`, default 9: tag width. The tag is `pc[ICACHE_IDX_W+ICACHE_TAG_W+1 : ICACHE_IDX_W+2]`, i.e. `pc[17:9]` at defaults.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc`  in  32  fetch address from the PC register; word aligned.
- `jump_flag`  in  1  redirect/flush from execute.
- `stall_in`  in  1  downstream stall; IF/ID cannot accept.
- `if_stall_req`  out  1  combinational; holds the PC register while high.
- `mem_req`  out  1  registered; fetch request to the memory controller.
- `mem_addr`  out  32  registered; byte address of the next byte wanted.
- `mem_byte_valid`  in  1  one pulse per returned byte.
- `mem_byte`  in  8  returned byte; valid when `mem_byte_valid` is high.
- `inst`  out  32  fetched instruction.
- `inst_pc`  out  32  address of `inst`.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a live instruction.

## Operation
- Cache line storage: a valid bit, an `ICACHE_TAG_W` tag and a 32-bit word.
- `hit` = valid[idx(pc)] && tag[idx(pc)] == tag(pc).
- States: `IDLE`, `FETCH`.
- Byte counter `cnt`, 2 bits. Fetch address `fetch_pc` and a 32-bit assembly buffer `buf` are latched.
- `if_stall_req` = (`IDLE` && !`hit`) || `FETCH`.
- Priority in all states: `rst` > `jump_flag` > `stall_in` > normal operation.

IDLE:
- On `jump_flag`: `inst_valid`←0; stay in `IDLE`.
- Else on `stall_in`: hold all outputs; no lookup side effects.
- Else on hit: `inst`←line word, `inst_pc`←`pc`, `inst_valid`←1.
- Else on miss:
  - `inst_valid`←0 (bubble).
  - `fetch_pc`←`pc`, `mem_req`←1, `mem_addr`←`pc`, `cnt`←0.
  - Go to `FETCH`.

FETCH:
- On each `mem_byte_valid`: `buf[8*cnt +: 8]`←`mem_byte` (little-endian), `cnt`←`cnt`+1, `mem_addr`←`fetch_pc`+`cnt`+1.
- On the 4th byte (`cnt`==3 && `mem_byte_valid`):
  - Write the line at idx(`fetch_pc`): valid←1, tag←tag(`fetch_pc`), word←assembled value.
  - `mem_req`←0; go to `IDLE`.
  - No direct output; the next `IDLE` cycle hits, since `pc` is held by the stall.
- On `jump_flag` without a 4th byte: abort.
  - `mem_req`←0, `inst_valid`←0, no cache write; go to `IDLE`.
  - The memory controller discards any bytes for a dropped request.
- `jump_flag` together with the 4th byte: the line is still written (its data is correct for `fetch_pc`), `inst_valid`←0, go to `IDLE`.
- `stall_in` during `FETCH` does not pause collection.

Other rules:
- `mem_byte_valid` in `IDLE` is ignored.
- Index and tag are taken from `pc` directly. Address bits above the tag alias.

## Timing
- Reset values:
  - state `IDLE`; `cnt` 0.
  - `inst`, `inst_pc`, `mem_addr`: 0.
  - `inst_valid`, `mem_req`: 0.
  - All valid bits 0.
  - `if_stall_req` is combinationally 1 after reset until the first line fills.
- Hit latency: `pc` presented in cycle N → `inst`/`inst_valid` registered at edge N+1.
- Miss latency, with the 4th byte arriving in cycle M:
  - `mem_req`=1 from cycle N+1.
  - Line written at edge M; hit in cycle M+1; output at edge M+1.
  - Minimum 6 cycles, with one byte per cycle starting at N+1.
- `mem_req` stays high continuously from request until the 4th byte or an abort, and drops the cycle after.
- Reset during `FETCH` returns to `IDLE` immediately; any partial `buf` is discarded.

## Test plan
- Reset, then `pc`=0:
  - `if_stall_req`=1 and `mem_req`=1 from cycle 1, `mem_addr`=0.
  - Feed bytes 0x13, 0x05, 0x10, 0x00 → `mem_addr` steps 1, 2, 3.
  - Then `inst`=0x00100513, `inst_pc`=0, `inst_valid`=1, `if_stall_req`=0.
- Hit after fill: `pc`=0 again → 1-cycle hit, no `mem_req`. Then `pc`=0x200 (same index, different tag) → miss; after fill, `pc`=0 misses again.
- `jump_flag` after 2 bytes of the `pc`=4 fetch:
  - `mem_req`=0 next cycle, `inst_valid`=0, state `IDLE`, line 1 still invalid.
  - Late `mem_byte_valid` pulses are ignored.
- `stall_in` held 3 cycles while hitting on `pc`=8: `inst`/`inst_pc`/`inst_valid` unchanged for all 3 cycles.
- `jump_flag` coincident with the 4th byte of `pc`=0x10: `inst_valid`=0; a later fetch of `pc`=0x10 hits in 1 cycle.
- `rst` mid-`FETCH` (after 1 byte): all outputs return to reset values and all lines become invalid.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage: direct-mapped instruction cache in front of a
// byte-serial memory controller. A hit registers the instruction one cycle
// after the PC is presented. A miss stalls the front end while the four
// bytes of the word are collected little-endian and written into the line.
module if_fetch #(
  parameter int ICACHE_IDX_W = 7,
  parameter int ICACHE_TAG_W = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        jump_flag,
  input  logic        stall_in,
  output logic        if_stall_req,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_byte_valid,
  input  logic [7:0]  mem_byte,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  localparam int ENTRIES = 1 << ICACHE_IDX_W;
  localparam int IDX_LO  = 2;
  localparam int IDX_HI  = ICACHE_IDX_W + 1;
  localparam int TAG_LO  = ICACHE_IDX_W + 2;
  localparam int TAG_HI  = ICACHE_IDX_W + ICACHE_TAG_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Cache storage: valid bits are control and clear on reset; tag and word
  // arrays are pure data and are only meaningful behind a set valid bit.
  logic [ENTRIES-1:0]      line_valid;
  logic [ICACHE_TAG_W-1:0] line_tag  [ENTRIES];
  logic [31:0]             line_word [ENTRIES];

  logic [1:0]  cnt;
  logic [31:0] fetch_pc;
  logic [31:0] asm_buf;

  logic [ICACHE_IDX_W-1:0] idx_p0;
  logic [ICACHE_TAG_W-1:0] tag_p0;
  logic                    hit_p0;
  logic [ICACHE_IDX_W-1:0] fetch_idx;
  logic [ICACHE_TAG_W-1:0] fetch_tag;
  logic                    start_fetch;
  logic                    byte_take;
  logic                    last_byte;
  logic [31:0]             fill_word;

  // Address bits outside index/tag alias onto the same line by design.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc[31:TAG_HI+1], pc[1:0]};

  assign idx_p0    = pc[IDX_HI:IDX_LO];
  assign tag_p0    = pc[TAG_HI:TAG_LO];
  assign hit_p0    = line_valid[idx_p0] && (line_tag[idx_p0] == tag_p0);
  assign fetch_idx = fetch_pc[IDX_HI:IDX_LO];
  assign fetch_tag = fetch_pc[TAG_HI:TAG_LO];

  // A miss only launches a fetch when neither a redirect nor a downstream
  // stall is pending. A byte arriving with a redirect is still taken if it
  // completes the word, because the line data is correct for fetch_pc.
  assign start_fetch = (state == IDLE) && !jump_flag && !stall_in && !hit_p0;
  assign byte_take   = (state == FETCH) && mem_byte_valid &&
                       (!jump_flag || (cnt == 2'd3));
  assign last_byte   = byte_take && (cnt == 2'd3);
  assign fill_word   = {mem_byte, asm_buf[23:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: leave IDLE on a clean miss, leave FETCH on completion or redirect.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_fetch) state_nxt = FETCH;
      FETCH:   if (jump_flag || last_byte) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: hold the PC register on a miss and throughout a fetch.
  always_comb begin
    if_stall_req = ((state == IDLE) && !hit_p0) || (state == FETCH);
  end

  // Control and output registers: lookup results, memory request, byte count, line valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 2'd0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'd0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      inst_valid <= 1'b0;
      line_valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (jump_flag) begin
            inst_valid <= 1'b0;
          end else if (stall_in) begin
            inst_valid <= inst_valid;
          end else if (hit_p0) begin
            inst       <= line_word[idx_p0];
            inst_pc    <= pc;
            inst_valid <= 1'b1;
          end else begin
            inst_valid <= 1'b0;
            mem_req    <= 1'b1;
            mem_addr   <= pc;
            cnt        <= 2'd0;
          end
        end
        FETCH: begin
          if (byte_take) begin
            cnt      <= cnt + 2'd1;
            mem_addr <= fetch_pc + 32'(cnt) + 32'd1;
          end
          if (last_byte) begin
            line_valid[fetch_idx] <= 1'b1;
            mem_req               <= 1'b0;
            if (jump_flag) inst_valid <= 1'b0;
          end else if (jump_flag) begin
            mem_req    <= 1'b0;
            inst_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Data registers: fetch address, byte assembly and line fill (no reset needed).
  always_ff @(posedge clk) begin
    if (start_fetch) fetch_pc <= pc;
    if (byte_take) asm_buf[{cnt, 3'b000} +: 8] <= mem_byte;
    if (last_byte) begin
      line_tag[fetch_idx]  <= fetch_tag;
      line_word[fetch_idx] <= fill_word;
    end
  end

endmodule
